// File: rtl/key_led_sequencer.sv
// Two debounced push-buttons select one of four LED patterns and pause/resume the stepping.
// A key press takes effect DB_CYCLES+3 cycles after the pin falls; there is no backpressure and all outputs are registered.

module key_led_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_press
);
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

    logic           r_sync1;
    logic           r_sync2;
    logic           r_db;
    logic           r_db_prev;
    logic [DBW-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_db      <= 1'b1;
            r_db_prev <= 1'b1;
            r_db_cnt  <= '0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            // Any sample that agrees with the accepted level restarts the stability window.
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db     <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Falling edge of the accepted level only; release is silent.
    assign o_press = r_db_prev & ~r_db;
endmodule

module key_led_sequencer #(
    parameter int DB_CYCLES   = 1000000,
    parameter int STEP_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       paused,
    output logic       step_tick
);
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ALL_ON = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);

    logic          w_mode_press;
    logic          w_pause_press;
    logic          w_stepping;
    logic          w_terminal;
    logic [2:0]    w_run_pos_nxt;
    mode_t         w_mode_nxt;

    mode_t         r_mode;
    logic          r_paused;
    logic          r_tick;
    logic          r_blink_on;
    logic [2:0]    r_run_pos;
    logic [7:0]    r_led;
    logic [SW-1:0] r_step_cnt;

    key_led_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .i_key   (key_mode),
        .o_press (w_mode_press)
    );

    key_led_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk     (clk),
        .rst     (rst),
        .i_key   (key_pause),
        .o_press (w_pause_press)
    );

    assign w_stepping    = ((r_mode == MODE_RUN) || (r_mode == MODE_BLINK)) && !r_paused;
    assign w_terminal    = (r_step_cnt == STEP_MAX);
    assign w_run_pos_nxt = r_run_pos + 3'd1;
    assign w_mode_nxt    = mode_t'(r_mode + 2'd1);

    function automatic logic [7:0] f_init_led(input mode_t m);
        case (m)
            MODE_ALL_ON: f_init_led = 8'h00;
            MODE_RUN:    f_init_led = 8'hFE;
            default:     f_init_led = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode     <= MODE_OFF;
            r_paused   <= 1'b0;
            r_tick     <= 1'b0;
            r_blink_on <= 1'b0;
            r_run_pos  <= 3'd0;
            r_led      <= 8'hFF;
            r_step_cnt <= '0;
        end else begin
            r_tick <= 1'b0;
            if (w_pause_press) begin
                r_paused <= ~r_paused;
            end
            // A mode change wins over a coincident terminal count and suppresses its tick.
            if (w_mode_press) begin
                r_mode     <= w_mode_nxt;
                r_step_cnt <= '0;
                r_run_pos  <= 3'd0;
                r_blink_on <= 1'b0;
                r_led      <= f_init_led(w_mode_nxt);
            end else if (w_stepping) begin
                if (w_terminal) begin
                    r_step_cnt <= '0;
                    r_tick     <= 1'b1;
                    if (r_mode == MODE_RUN) begin
                        r_run_pos <= w_run_pos_nxt;
                        r_led     <= ~(8'h01 << w_run_pos_nxt);
                    end else begin
                        r_blink_on <= ~r_blink_on;
                        r_led      <= r_blink_on ? 8'hFF : 8'h00;
                    end
                end else begin
                    r_step_cnt <= r_step_cnt + 1'b1;
                end
            end
        end
    end

    assign led       = r_led;
    assign mode      = r_mode;
    assign paused    = r_paused;
    assign step_tick = r_tick;
endmodule

// File: tb/tb_key_led_sequencer.sv
// Bench for key_led_sequencer: directed key sequences plus random key activity,
// compared every cycle against a step-count based model of the LED sequencer.
module tb_key_led_sequencer;
    localparam int DB = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode = 1'b1;
    logic       key_pause = 1'b1;
    logic [7:0] led;
    logic [1:0] mode;
    logic       paused;
    logic       step_tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_led_sequencer #(.DB_CYCLES(DB), .STEP_CYCLES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_pause (key_pause),
        .led       (led),
        .mode      (mode),
        .paused    (paused),
        .step_tick (step_tick)
    );

    // Model: keys reach the filter two edges late; a level is accepted after DB
    // consecutive disagreeing samples; a falling acceptance acts one edge later.
    // The LED is a function of the mode and of the number of steps since mode entry.
    int m_mode  = 0;
    bit m_paused = 1'b0;
    int m_cnt   = 0;
    int m_steps = 0;
    bit m_tick  = 1'b0;
    bit m_d1[2]   = '{1'b1, 1'b1};
    bit m_d2[2]   = '{1'b1, 1'b1};
    bit m_lvl[2]  = '{1'b1, 1'b1};
    bit m_pend[2] = '{1'b0, 1'b0};
    int m_run[2]  = '{0, 0};

    always @(posedge clk) begin : model
        bit mp;
        bit pp;
        bit old_paused;
        bit smp;
        if (!rst) begin
            m_mode = 0; m_paused = 1'b0; m_cnt = 0; m_steps = 0; m_tick = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_d1[i] = 1'b1; m_d2[i] = 1'b1; m_lvl[i] = 1'b1;
                m_pend[i] = 1'b0; m_run[i] = 0;
            end
        end else begin
            mp = m_pend[0];
            pp = m_pend[1];
            old_paused = m_paused;
            m_tick = 1'b0;
            if (pp) m_paused = !m_paused;
            if (mp) begin
                m_mode = (m_mode + 1) % 4;
                m_cnt = 0;
                m_steps = 0;
            end else if (m_mode >= 2 && !old_paused) begin
                if (m_cnt == ST - 1) begin
                    m_cnt = 0; m_tick = 1'b1; m_steps++;
                end else begin
                    m_cnt++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 1'b0;
                smp = m_d2[i];
                if (smp == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = smp;
                        m_run[i] = 0;
                        m_pend[i] = !smp;
                    end
                end
            end
            m_d2[0] = m_d1[0]; m_d1[0] = key_mode;
            m_d2[1] = m_d1[1]; m_d1[1] = key_pause;
        end
    end

    function automatic logic [7:0] exp_led(input int md, input int st);
        logic [7:0] one;
        one = 8'h01;
        case (md)
            0:       return 8'hFF;
            1:       return 8'h00;
            2:       return ~(one << (st % 8));
            default: return ((st % 2) != 0) ? 8'h00 : 8'hFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("led", led, exp_led(m_mode, m_steps));
        chk("mode", 8'(mode), 8'(m_mode));
        chk("paused", 8'(paused), 8'(m_paused));
        chk("step_tick", 8'(step_tick), 8'(m_tick));
    endtask

    task automatic mode_press_checked(input logic [1:0] exp_mode, input logic [7:0] exp_led_v);
        int changes;
        logic [1:0] prev;
        changes = 0;
        prev = mode;
        key_mode = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) key_mode = 1'b1;
            cyc();
            if (mode !== prev) begin
                changes++;
                chk("mode_entry", 8'(mode), 8'(exp_mode));
                chk("led_entry", led, exp_led_v);
            end
            prev = mode;
        end
        chk("mode_one_increment", 8'(changes), 8'd1);
    endtask

    task automatic pause_press_checked(input logic exp_p);
        int changes;
        logic prev;
        changes = 0;
        prev = paused;
        key_pause = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) key_pause = 1'b1;
            cyc();
            if (paused !== prev) begin
                changes++;
                chk("pause_entry", 8'(paused), 8'(exp_p));
            end
            prev = paused;
        end
        chk("pause_one_toggle", 8'(changes), 8'd1);
    endtask

    task automatic wait_tick(input int budget, output int waited);
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (step_tick !== 1'b1 && waited < budget);
        chk("tick_seen", 8'(step_tick), 8'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        int sel;
        int pos0;
        int seen;
        logic [1:0] prev_m;
        logic [7:0] frozen;
        logic [7:0] one;
        one = 8'h01;

        // Reset and idle
        rst = 1'b0;
        repeat (2) cyc();
        chk("rst_led", led, 8'hFF);
        chk("rst_mode", 8'(mode), 8'd0);
        chk("rst_paused", 8'(paused), 8'd0);
        rst = 1'b1;
        repeat (10) cyc();

        // Mode cycle 0 -> 1 -> 2 -> 3 -> 0
        mode_press_checked(2'd1, 8'h00);
        mode_press_checked(2'd2, 8'hFE);
        mode_press_checked(2'd3, 8'hFF);
        mode_press_checked(2'd0, 8'hFF);

        // Short pulses must be rejected
        key_mode = 1'b0;
        repeat (3) cyc();
        key_mode = 1'b1;
        repeat (10) cyc();
        chk("glitch_mode", 8'(mode), 8'd0);
        repeat (6) begin
            w = $urandom_range(1, DB - 1);
            sel = $urandom_range(0, 1);
            if (sel != 0) key_pause = 1'b0;
            else key_mode = 1'b0;
            repeat (w) cyc();
            key_mode = 1'b1;
            key_pause = 1'b1;
            repeat ($urandom_range(2, 6)) cyc();
        end
        repeat (6) cyc();
        chk("glitch_mode_rand", 8'(mode), 8'd0);
        chk("glitch_paused_rand", 8'(paused), 8'd0);

        // RUN: tick every ST cycles, lit bit walks left and wraps
        mode_press_checked(2'd1, 8'h00);
        mode_press_checked(2'd2, 8'hFE);
        pos0 = 0;
        for (int k = 0; k < 10; k++) begin
            wait_tick(8, w);
            if (k == 0) pos0 = m_steps % 8;
            else chk("tick_gap", 8'(w), 8'(ST));
            chk("run_led", led, ~(one << ((pos0 + k) % 8)));
        end

        // BLINK: pause mid-count, stay frozen, resume
        mode_press_checked(2'd3, 8'hFF);
        wait_tick(8, w);
        cyc();
        pause_press_checked(1'b1);
        frozen = exp_led(m_mode, m_steps);
        repeat (20) begin
            cyc();
            chk("frozen_tick", 8'(step_tick), 8'd0);
            chk("frozen_led", led, frozen);
        end
        pause_press_checked(1'b0);
        wait_tick(8, w);

        // Back to RUN, then both keys together
        mode_press_checked(2'd0, 8'hFF);
        mode_press_checked(2'd1, 8'h00);
        mode_press_checked(2'd2, 8'hFE);
        seen = 0;
        prev_m = mode;
        key_mode = 1'b0;
        key_pause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (mode !== prev_m) begin
                seen++;
                chk("both_mode", 8'(mode), 8'd3);
                chk("both_paused", 8'(paused), 8'd1);
                chk("both_led", led, 8'hFF);
            end
            prev_m = mode;
        end
        chk("both_seen", 8'(seen), 8'd1);

        // Reset mid-operation with keys still held
        rst = 1'b0;
        repeat (2) cyc();
        chk("rst2_led", led, 8'hFF);
        chk("rst2_mode", 8'(mode), 8'd0);
        chk("rst2_paused", 8'(paused), 8'd0);
        chk("rst2_tick", 8'(step_tick), 8'd0);
        rst = 1'b1;
        repeat (12) cyc();
        chk("held_mode", 8'(mode), 8'd1);
        chk("held_paused", 8'(paused), 8'd1);
        key_mode = 1'b1;
        key_pause = 1'b1;
        repeat (10) cyc();

        // Random key activity with occasional resets
        repeat (60) begin
            key_mode = 1'($urandom_range(0, 1));
            key_pause = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) rst = 1'b0;
            repeat ($urandom_range(1, 12)) begin
                cyc();
                rst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_led_sequencer.md
KEY_LED_SEQUENCER -- requirements
Module: key_led_sequencer

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, meaning the number of consecutive stable sampled-key cycles required to accept a level change.
REQ-002 The block SHALL have parameter STEP_CYCLES, default 25000000, meaning the number of clock cycles per pattern step.
REQ-003 Port clk: input, 1 bit, system clock; all state updates on the rising edge.
REQ-004 Port rst: input, 1 bit; reset rst, synchronous, active-low.
REQ-005 Port key_mode: input, 1 bit, asynchronous push-button, active-low; a press advances the mode.
REQ-006 Port key_pause: input, 1 bit, asynchronous push-button, active-low; a press toggles pause.
REQ-007 Port led: output, 8 bits, registered, active-low (1 = LED off).
REQ-008 Port mode: output, 2 bits, registered current mode.
REQ-009 Port paused: output, 1 bit, registered pause flag.
REQ-010 Port step_tick: output, 1 bit, registered one-cycle pulse when the pattern advances.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized key SHALL have its own debounce counter: it clears on any sample equal to the debounced state; otherwise it counts, and the debounced state flips when the count reaches DB_CYCLES-1.
REQ-013 A press event SHALL be a single-cycle internal pulse on the cycle after the debounced state goes 1->0; release (0->1) SHALL generate no event.
REQ-014 Mode encoding SHALL be: 0 OFF, 1 ALL_ON, 2 RUN, 3 BLINK; each mode_press advances mode 0->1->2->3->0, with wrap from 3 to 0.
REQ-015 On a mode change, the step counter SHALL clear, the RUN position SHALL return to bit 0, the BLINK phase SHALL return to off, and led SHALL show the new mode's initial pattern in the same cycle that mode updates.
REQ-016 led patterns SHALL be: OFF 8'hFF; ALL_ON 8'h00; RUN a single 0 bit at the current position (initially 8'hFE); BLINK alternating between 8'hFF and 8'h00, starting at 8'hFF.
REQ-017 The step counter SHALL count 0..STEP_CYCLES-1 only while the mode is RUN or BLINK and paused=0.
REQ-018 At the terminal count, the step counter SHALL wrap to 0, step_tick SHALL pulse for one cycle, and the pattern SHALL advance in that same cycle.
REQ-019 In RUN, each step SHALL move the lit LED left, from bit i to bit i+1, and wrap from bit 7 to bit 0.
REQ-020 In OFF and ALL_ON, the step counter SHALL be held at 0 and step_tick SHALL stay at 0.
REQ-021 Each pause_press SHALL toggle paused; while paused=1, the step counter and pattern SHALL freeze and step_tick SHALL stay at 0; on unpause, counting SHALL resume from the held count.
REQ-022 A mode change SHALL NOT alter paused.
REQ-023 Simultaneous mode_press and pause_press SHALL both take effect in the same cycle.
REQ-024 A mode_press coinciding with a step terminal count SHALL take priority: the mode-change initialization applies and no step_tick is issued.
REQ-025 A key held low indefinitely SHALL produce exactly one press event.
REQ-026 Glitches shorter than DB_CYCLES cycles SHALL produce no event.

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL set: mode=0, paused=0, led=8'hFF, step_tick=0, step counter=0, RUN position=0, BLINK phase=off, debounce counters=0, debounced key states=1, synchronizer flops=1.
REQ-028 A reset asserted mid-operation SHALL abort any debounce in progress and discard any pending press; a key still held low after reset release SHALL register as a new press once DB_CYCLES is satisfied.

Verification (DB_CYCLES=4, STEP_CYCLES=3)
REQ-029 Bench SHALL check: rst=0 for 2 cycles, then rst=1 with keys high -> led=8'hFF, mode=0, paused=0, step_tick never asserted.
REQ-030 Bench SHALL check: key_mode low for 10 cycles -> exactly one mode increment, mode=1, led=8'h00; repeating the press three more times gives mode 2, 3, 0, with led=8'hFE on entering mode 2 and led=8'hFF on returning to mode 0.
REQ-031 Bench SHALL check: key_mode low for 3 cycles, then high -> no mode change.
REQ-032 Bench SHALL check: in RUN, free-running -> step_tick every 3 cycles; led sequence FE, FD, FB, ..., 7F, FE (wrap).
REQ-033 Bench SHALL check: in BLINK, press key_pause mid-count -> paused=1, led frozen for 20 cycles; press key_pause again -> paused=0, next step_tick arrives after the remaining count.
REQ-034 Bench SHALL check: both keys pressed in the same cycle while in RUN with paused=0 -> mode=3, paused=1, led=8'hFF in the same cycle; then rst=0 mid-count -> all outputs return to their REQ-027 values.
